axi_read_responder: RTL and testbench

AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

---
 rtl/axi_read_responder.sv | 149 ++++++++++++++
 tb/tb_axi_read_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_read_responder
// Description : Single-outstanding AXI-style read responder backed by a
//               preloadable word memory. Optional wrapping (critical-word-
//               first) bursts are enabled with AXI_RESP_CRITICAL_WORD_FIRST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_read_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int LATENCY        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic [7:0]                ARLEN,
    input  logic [3:0]                ARID,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [3:0]                RID,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY,
    input  logic                      pre_we,
    input  logic [MEM_WORDS_LOG2-1:0] pre_addr,
    input  logic [DATA_WIDTH-1:0]     pre_wdata
);

    localparam int         c_MEM_DEPTH = 1 << MEM_WORDS_LOG2;
    localparam logic [3:0] c_LAT_LOAD  = 4'(LATENCY - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_BURST = 2'd2;

    logic [DATA_WIDTH-1:0]     r_mem [c_MEM_DEPTH];
    logic [1:0]                r_state;
    logic [3:0]                r_lat;
    logic [8:0]                r_beats;
    logic [MEM_WORDS_LOG2-1:0] r_idx;
    logic [3:0]                r_id;

    logic [7:0]                w_len;
    logic [8:0]                w_beats_in;
    logic [MEM_WORDS_LOG2-1:0] w_idx_start;
    logic [MEM_WORDS_LOG2-1:0] w_idx_next;
    logic                      w_ar_hs;
    logic                      w_r_hs;
    logic                      w_unused_addr;

    // Byte offset within a word and address bits above the memory are unused.
    if (ADDR_WIDTH > MEM_WORDS_LOG2 + 2) begin : g_addr_hi
        assign w_unused_addr = ^{ARADDR[ADDR_WIDTH-1:MEM_WORDS_LOG2+2], ARADDR[1:0]};
    end else begin : g_addr_exact
        assign w_unused_addr = ^ARADDR[1:0];
    end

    assign w_len       = (ARLEN == 8'd0) ? 8'd1 : ARLEN;
    assign w_idx_start = ARADDR[MEM_WORDS_LOG2+1:2];

    // Reset gates acceptance directly so ARREADY is low for the whole reset.
    assign ARREADY = (r_state == c_ST_IDLE) && !rst;
    assign RVALID  = (r_state == c_ST_BURST);
    assign RLAST   = RVALID && (r_beats == 9'd1);
    assign RDATA   = r_mem[r_idx];
    assign RID     = r_id;
    assign w_ar_hs = ARVALID && ARREADY;
    assign w_r_hs  = RVALID && RREADY;

`ifdef AXI_RESP_CRITICAL_WORD_FIRST_EN
    logic [7:0]                w_span;
    logic [MEM_WORDS_LOG2-1:0] w_idx_inc;
    logic [MEM_WORDS_LOG2-1:0] r_wrap_mask;

    // Smear len-1 rightwards to get the power-of-two block mask.
    always_comb begin
        w_span = w_len - 8'd1;
        w_span = w_span | (w_span >> 1);
        w_span = w_span | (w_span >> 2);
        w_span = w_span | (w_span >> 4);
    end

    assign w_beats_in = {1'b0, w_span} + 9'd1;
    assign w_idx_inc  = r_idx + MEM_WORDS_LOG2'(1);
    assign w_idx_next = (r_idx & ~r_wrap_mask) | (w_idx_inc & r_wrap_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap_mask <= '0;
        end else if (w_ar_hs) begin
            r_wrap_mask <= MEM_WORDS_LOG2'(w_span);
        end
    end
`else
    assign w_beats_in = {1'b0, w_len};
    assign w_idx_next = r_idx + MEM_WORDS_LOG2'(1);
`endif

    // Preload port has no reset so memory survives rst.
    always_ff @(posedge clk) begin
        if (pre_we) begin
            r_mem[pre_addr] <= pre_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_lat   <= 4'd0;
            r_beats <= 9'd0;
            r_idx   <= '0;
            r_id    <= 4'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_ar_hs) begin
                        r_state <= c_ST_WAIT;
                        r_lat   <= c_LAT_LOAD;
                        r_beats <= w_beats_in;
                        r_idx   <= w_idx_start;
                        r_id    <= ARID;
                    end
                end
                c_ST_WAIT: begin
                    if (r_lat == 4'd0) begin
                        r_state <= c_ST_BURST;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                c_ST_BURST: begin
                    if (w_r_hs) begin
                        r_beats <= r_beats - 9'd1;
                        r_idx   <= w_idx_next;
                        if (r_beats == 9'd1) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_read_responder
// Description : Self-checking bench for axi_read_responder with a reference
//               memory model and burst-address model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_read_responder;

    localparam int c_AW    = 32;
    localparam int c_DW    = 32;
    localparam int c_ML    = 12;
    localparam int c_LAT   = 2;
    localparam int c_DEPTH = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [c_AW-1:0]   ARADDR = '0;
    logic [7:0]        ARLEN = '0;
    logic [3:0]        ARID = '0;
    logic              ARVALID = 1'b0;
    logic              ARREADY;
    logic [c_DW-1:0]   RDATA;
    logic [3:0]        RID;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY = 1'b0;
    logic              pre_we = 1'b0;
    logic [c_ML-1:0]   pre_addr = '0;
    logic [c_DW-1:0]   pre_wdata = '0;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_mem [c_DEPTH];
    bit   [6:0]  stall_pat = 7'b1101001;

    always #5 clk = ~clk;

    axi_read_responder #(
        .ADDR_WIDTH    (c_AW),
        .DATA_WIDTH    (c_DW),
        .MEM_WORDS_LOG2(c_ML),
        .LATENCY       (c_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ARADDR   (ARADDR),
        .ARLEN    (ARLEN),
        .ARID     (ARID),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RID      (RID),
        .RLAST    (RLAST),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .pre_we   (pre_we),
        .pre_addr (pre_addr),
        .pre_wdata(pre_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Number of beats a request of ARLEN=len produces.
    function automatic int beats_of(input int len);
        int n = (len == 0) ? 1 : len;
`ifdef AXI_RESP_CRITICAL_WORD_FIRST_EN
        int p = 1;
        while (p < n) p = p * 2;
        return p;
`else
        return n;
`endif
    endfunction

    // Word index of beat k of a burst starting at word 'start'.
    function automatic int word_of(input int start, input int len, input int k);
`ifdef AXI_RESP_CRITICAL_WORD_FIRST_EN
        int n = beats_of(len);
        return (start - (start % n)) + ((start % n) + k) % n;
`else
        return (start + k + 0 * len) % c_DEPTH;
`endif
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        pre_we    = 1'b1;
        pre_addr  = 12'(idx);
        pre_wdata = d;
        @(negedge clk);
        pre_we    = 1'b0;
        model_mem[idx] = d;
    endtask

    task automatic accept_ar(input logic [31:0] addr, input int len, input int id, output int waited);
        ARADDR  = addr;
        ARLEN   = 8'(len);
        ARID    = 4'(id);
        ARVALID = 1'b1;
        waited  = 0;
        while (ARREADY !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        chk("ar_accept_timeout", 64'(waited < 64), 64'd1);
        @(negedge clk);
        ARVALID = 1'b0;
    endtask

    // Called at the first negedge after the accepting edge.
    task automatic collect(input int start, input int len, input int id, input int mode, output int ncyc);
        int  n;
        int  b;
        int  k;
        bit  rdy;
        n = beats_of(len);
        chk("arready_drop", ARREADY, 0);
        k = 0;
        while (RVALID !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("first_rvalid_latency", k, c_LAT);
        b    = 0;
        ncyc = 0;
        while (b < n && ncyc < 2000) begin
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = stall_pat[ncyc % 7];
            else                rdy = 1'($urandom_range(0, 1));
            RREADY = rdy;
            chk("beat_rvalid", RVALID, 1);
            chk("beat_rdata", RDATA, model_mem[word_of(start, len, b)]);
            chk("beat_rid", RID, id);
            chk("beat_rlast", RLAST, 64'(b == n - 1));
            chk("beat_arready", ARREADY, 0);
            if (rdy) b++;
            ncyc++;
            @(negedge clk);
        end
        RREADY = 1'b0;
        chk("post_burst_rvalid", RVALID, 0);
        chk("post_burst_rlast", RLAST, 0);
        chk("post_burst_arready", ARREADY, 1);
    endtask

    initial begin
        int w;
        int nc;
        int k;
        int word;
        int len;
        int id;

        for (int i = 0; i < c_DEPTH; i++) model_mem[i] = '0;
        repeat (2) @(negedge clk);

        // Preload while held in reset, then check reset outputs.
        for (int i = 0; i < 4; i++) preload(32'h100 + i, 32'hA0 + i);
        chk("rst_arready", ARREADY, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_rid", RID, 0);
        rst = 1'b0;
        #1;
        chk("arready_after_rst", ARREADY, 1);
        @(negedge clk);
        preload(32'h104, 32'hB4);
        preload(32'h105, 32'hB5);
        preload(1, 32'h11);
        preload(16, 32'h1600);
        preload(17, 32'h1700);
        for (int i = 0; i < 4; i++) preload(32'hFFC + i, 32'hF0 + i);

        // Basic 4-beat burst, RREADY held high.
        accept_ar(32'h400, 4, 2, w);
        collect(32'h100, 4, 2, 0, nc);
        chk("basic_cycles", nc, 4);

        // Same burst with stalls.
        accept_ar(32'h400, 4, 2, w);
        collect(32'h100, 4, 2, 1, nc);
        chk("stall_burst_cycles", nc, 7);

        // Mid-block start.
        accept_ar(32'h408, 4, 5, w);
        collect(32'h102, 4, 5, 0, nc);

        // ARLEN=0 gives one beat.
        accept_ar(32'h4, 0, 7, w);
        collect(1, 0, 7, 0, nc);
        chk("len0_cycles", nc, 1);

        // Read-before-write on the word being presented.
        accept_ar(32'h40, 2, 3, w);
        k = 0;
        while (RVALID !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        RREADY    = 1'b0;
        pre_we    = 1'b1;
        pre_addr  = 12'd16;
        pre_wdata = 32'hC0FFEE01;
        #1;
        chk("rbw_old_data", RDATA, model_mem[16]);
        @(negedge clk);
        pre_we = 1'b0;
        model_mem[16] = 32'hC0FFEE01;
        chk("rbw_new_data", RDATA, model_mem[16]);
        RREADY = 1'b1;
        @(negedge clk);
        chk("rbw_beat2_data", RDATA, model_mem[word_of(16, 2, 1)]);
        chk("rbw_beat2_last", RLAST, 1);
        @(negedge clk);
        RREADY = 1'b0;
        chk("rbw_done", RVALID, 0);

        // Pending AR held through a burst.
        accept_ar(32'h400, 4, 4, w);
        ARADDR  = 32'h408;
        ARLEN   = 8'd2;
        ARID    = 4'd12;
        ARVALID = 1'b1;
        collect(32'h100, 4, 4, 0, nc);
        accept_ar(32'h408, 2, 12, w);
        chk("pending_ar_wait", w, 0);
        collect(32'h102, 2, 12, 0, nc);

        // Reset during the second beat.
        accept_ar(32'h400, 4, 9, w);
        k = 0;
        while (RVALID !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        RREADY = 1'b1;
        chk("rstb_beat0", RDATA, model_mem[32'h100]);
        @(negedge clk);
        chk("rstb_beat1", RDATA, model_mem[32'h101]);
        rst = 1'b1;
        @(negedge clk);
        chk("rstb_rvalid_drop", RVALID, 0);
        chk("rstb_arready_in_rst", ARREADY, 0);
        chk("rstb_rid_clear", RID, 0);
        @(negedge clk);
        chk("rstb_rvalid_still", RVALID, 0);
        rst    = 1'b0;
        RREADY = 1'b0;
        #1;
        chk("rstb_arready_after", ARREADY, 1);
        @(negedge clk);
        accept_ar(32'h400, 4, 10, w);
        collect(32'h100, 4, 10, 0, nc);

        // Index wrap at the top of memory.
        accept_ar(32'h3FF8, 4, 1, w);
        collect(32'hFFE, 4, 1, 0, nc);

        // Randomized bursts over a freshly randomized region.
        for (int i = 0; i < 32'h300; i++) preload(i, $urandom);
        for (int t = 0; t < 24; t++) begin
            word = int'($urandom_range(0, 511));
            len  = int'($urandom_range(0, 16));
            id   = int'($urandom_range(0, 15));
            accept_ar((32'(word) << 2) | 32'($urandom_range(0, 3)), len, id, w);
            collect(word, len, id, 2, nc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
